// File: rtl/decode_stage.sv
// RV32I decode with a 2-entry output skid FIFO and an illegal-instruction counter.
// Optional M-extension decode is enabled by defining DECODE_RV32M_EN.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [RA_W-1:0]  rs1,
  output logic [RA_W-1:0]  rs2,
  output logic [RA_W-1:0]  rd,
  output logic [1:0]       r_w_src,
  output logic             alu_imm_b,
  output logic             alu_pc_a,
  output logic [2:0]       alu_op,
  output logic             alu_alt,
  output logic             alu_mul,
  output logic [XLEN-1:0]  imm,
  output logic             cmp_z,
  output logic             cmp_inv,
  output logic [1:0]       bra_mode,
  output logic             mem_en,
  output logic             mem_rw,
  output logic [2:0]       mem_func,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("decode_stage: XLEN must be 32 or 64");
  end
  if (RA_W > 5 || RA_W < 1) begin : g_bad_ra_w
    $error("decode_stage: RA_W must be 1..5");
  end

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [1:0]      r_w_src;
    logic            alu_imm_b;
    logic            alu_pc_a;
    logic [2:0]      alu_op;
    logic            alu_alt;
    logic            alu_mul;
    logic [XLEN-1:0] imm;
    logic            cmp_z;
    logic            cmp_inv;
    logic [1:0]      bra_mode;
    logic            mem_en;
    logic            mem_rw;
    logic [2:0]      mem_func;
    logic            illegal;
  } dec_t;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic [31:0] imm32;
  logic        use_rs1, use_rs2, use_rd, ill;
  dec_t        dec;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign rs1_f = in_instr[19:15];
  assign rs2_f = in_instr[24:20];
  assign rd_f  = in_instr[11:7];

  // Combinational decode; illegal encodings collapse to an all-zero entry.
  always_comb begin
    dec     = '0;
    imm32   = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    ill     = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (opc)
        7'b0110111, 7'b0010111: begin
          imm32         = {in_instr[31:12], 12'b0};
          use_rd        = 1'b1;
          dec.alu_imm_b = 1'b1;
          dec.alu_pc_a  = ~opc[5];
          dec.r_w_src   = 2'b01;
        end
        7'b1101111: begin
          imm32 = {{12{in_instr[31]}}, in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
          use_rd       = 1'b1;
          dec.r_w_src  = 2'b11;
          dec.bra_mode = 2'b01;
        end
        7'b1100111: begin
          imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
          use_rs1       = 1'b1;
          use_rd        = 1'b1;
          dec.alu_imm_b = 1'b1;
          dec.r_w_src   = 2'b11;
          dec.bra_mode  = 2'b11;
          ill           = (f3 != 3'b000);
        end
        7'b0000011: begin
          imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
          use_rs1       = 1'b1;
          use_rd        = 1'b1;
          dec.alu_imm_b = 1'b1;
          dec.r_w_src   = 2'b10;
          dec.mem_en    = 1'b1;
          dec.mem_func  = f3;
          ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        end
        7'b0100011: begin
          imm32 = {{20{in_instr[31]}}, in_instr[31:25],
                   in_instr[11:7]};
          use_rs1       = 1'b1;
          use_rs2       = 1'b1;
          dec.alu_imm_b = 1'b1;
          dec.mem_en    = 1'b1;
          dec.mem_rw    = 1'b1;
          dec.mem_func  = f3;
          ill           = (f3 > 3'b010);
        end
        7'b1100011: begin
          imm32 = {{20{in_instr[31]}}, in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
          use_rs1      = 1'b1;
          use_rs2      = 1'b1;
          dec.bra_mode = 2'b10;
          dec.cmp_z    = ~f3[2];
          dec.cmp_inv  = f3[0];
          ill          = (f3[2:1] == 2'b01);
        end
        7'b0010011: begin
          imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
          use_rs1       = 1'b1;
          use_rd        = 1'b1;
          dec.alu_imm_b = 1'b1;
          dec.alu_op    = f3;
          dec.alu_alt   = (f3 == 3'b101) & in_instr[30];
          dec.r_w_src   = 2'b01;
        end
        7'b0110011: begin
          use_rs1     = 1'b1;
          use_rs2     = 1'b1;
          use_rd      = 1'b1;
          dec.alu_op  = f3;
          dec.r_w_src = 2'b01;
          if (f7 == 7'b0000000 || f7 == 7'b0100000)
            dec.alu_alt = in_instr[30];
`ifdef DECODE_RV32M_EN
          else if (f7 == 7'b0000001)
            dec.alu_mul = 1'b1;
`endif
          else
            ill = 1'b1;
        end
        default: ill = 1'b1;
      endcase
    end
    dec.imm = XLEN'($signed(imm32));
    dec.rs1 = use_rs1 ? rs1_f[RA_W-1:0] : '0;
    dec.rs2 = use_rs2 ? rs2_f[RA_W-1:0] : '0;
    dec.rd  = use_rd  ? rd_f[RA_W-1:0]  : '0;
    dec.pc  = in_pc;
    if (ill) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.illegal = 1'b1;
    end
  end

  dec_t             slot0_q, slot0_d, slot1_q, slot1_d, head;
  logic [1:0]       cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic             push, pop;

  assign push = in_valid & rdy_q & ~flush;
  assign pop  = (cnt_q != 2'd0) & out_ready;

  // FIFO next state; in_ready is precomputed from the next count.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    icnt_d  = icnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push) begin
            slot0_d = dec;
            cnt_d   = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            slot0_d = dec;
          end else if (push) begin
            slot1_d = dec;
            cnt_d   = 2'd2;
          end else if (pop) begin
            cnt_d = 2'd0;
          end
        end
        default: begin
          if (pop) begin
            slot0_d = slot1_q;
            cnt_d   = 2'd1;
          end
        end
      endcase
    end
    rdy_d = (cnt_d != 2'd2);
    if (push && dec.illegal && icnt_q != '1)
      icnt_d = icnt_q + CNT_W'(1);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= 2'd0;
      rdy_q   <= 1'b1;
      icnt_q  <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      icnt_q  <= icnt_d;
    end
  end

  assign out_valid   = (cnt_q != 2'd0);
  assign in_ready    = rdy_q;
  assign illegal_cnt = icnt_q;
  assign head        = out_valid ? slot0_q : '0;

  assign out_pc    = head.pc;
  assign rs1       = head.rs1;
  assign rs2       = head.rs2;
  assign rd        = head.rd;
  assign r_w_src   = head.r_w_src;
  assign alu_imm_b = head.alu_imm_b;
  assign alu_pc_a  = head.alu_pc_a;
  assign alu_op    = head.alu_op;
  assign alu_alt   = head.alu_alt;
  assign alu_mul   = head.alu_mul;
  assign imm       = head.imm;
  assign cmp_z     = head.cmp_z;
  assign cmp_inv   = head.cmp_inv;
  assign bra_mode  = head.bra_mode;
  assign mem_en    = head.mem_en;
  assign mem_rw    = head.mem_rw;
  assign mem_func  = head.mem_func;
  assign illegal   = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table, backpressure,
// flush, reset and illegal counter saturation.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  r_w_src, bra_mode;
  logic        alu_imm_b, alu_pc_a, alu_alt, alu_mul;
  logic [2:0]  alu_op, mem_func;
  logic        cmp_z, cmp_inv, mem_en, mem_rw, illegal;
  logic [7:0]  illegal_cnt;
  logic [18:0] ctrl;

  int nchk = 0;
  int nerr = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .r_w_src(r_w_src), .alu_imm_b(alu_imm_b),
    .alu_pc_a(alu_pc_a), .alu_op(alu_op),
    .alu_alt(alu_alt), .alu_mul(alu_mul), .imm(imm),
    .cmp_z(cmp_z), .cmp_inv(cmp_inv),
    .bra_mode(bra_mode), .mem_en(mem_en),
    .mem_rw(mem_rw), .mem_func(mem_func),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  assign ctrl = {r_w_src, alu_imm_b, alu_pc_a, alu_op,
                 alu_alt, alu_mul, cmp_z, cmp_inv,
                 bra_mode, mem_en, mem_rw, mem_func, illegal};

  function automatic logic [18:0] mk(
    input int rws, input int immb, input int pca,
    input int op, input int alt, input int mul,
    input int cz, input int ci, input int bm,
    input int me, input int mrw, input int mf,
    input int ill);
    return {2'(rws), 1'(immb), 1'(pca), 3'(op),
            1'(alt), 1'(mul), 1'(cz), 1'(ci),
            2'(bm), 1'(me), 1'(mrw), 3'(mf), 1'(ill)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] v_ins [15];
  logic [31:0] v_imm [15];
  logic [18:0] v_ctl [15];
  int          v_rd  [15];
  int          v_rs1 [15];
  int          v_rs2 [15];

  task automatic setv(input int i, input logic [31:0] ins,
                      input int d, input int s1, input int s2,
                      input logic [31:0] im,
                      input logic [18:0] c);
    v_ins[i] = ins; v_rd[i] = d; v_rs1[i] = s1;
    v_rs2[i] = s2;  v_imm[i] = im; v_ctl[i] = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    out_ready = 1'b0; in_instr = '0; in_pc = '0;
    step(); step();
    nchk++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    nchk++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    nchk++;
    if (illegal_cnt !== 8'd0) begin
      nerr++;
      $display("FAIL reset_cnt got %0d want 0", illegal_cnt);
    end
    nchk++;
    if ({ctrl, rd, rs1, rs2, imm, out_pc} !== '0) begin
      nerr++;
      $display("FAIL reset_fields got ctrl=%h imm=%h", ctrl, imm);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_decode();
    setv(0, 32'h00500093, 1, 0, 0, 32'd5,
         mk(1,1,0,0,0,0,0,0,0,0,0,0,0));
    setv(1, 32'hFE208EE3, 0, 1, 2, 32'hFFFFFFFC,
         mk(0,0,0,0,0,0,1,0,2,0,0,0,0));
    setv(2, 32'h123450B7, 1, 0, 0, 32'h12345000,
         mk(1,1,0,0,0,0,0,0,0,0,0,0,0));
    setv(3, 32'h00001117, 2, 0, 0, 32'h00001000,
         mk(1,1,1,0,0,0,0,0,0,0,0,0,0));
    setv(4, 32'h008000EF, 1, 0, 0, 32'd8,
         mk(3,0,0,0,0,0,0,0,1,0,0,0,0));
    setv(5, 32'h00008067, 0, 1, 0, 32'd0,
         mk(3,1,0,0,0,0,0,0,3,0,0,0,0));
    setv(6, 32'hFFF10083, 1, 2, 0, 32'hFFFFFFFF,
         mk(2,1,0,0,0,0,0,0,0,1,0,0,0));
    setv(7, 32'h0020A423, 0, 1, 2, 32'd8,
         mk(0,1,0,0,0,0,0,0,0,1,1,2,0));
    setv(8, 32'h4030D093, 1, 1, 0, 32'h00000403,
         mk(1,1,0,5,1,0,0,0,0,0,0,0,0));
    setv(9, 32'h402081B3, 3, 1, 2, 32'd0,
         mk(1,0,0,0,1,0,0,0,0,0,0,0,0));
    setv(10, 32'h0020D463, 0, 1, 2, 32'd8,
         mk(0,0,0,0,0,0,0,1,2,0,0,0,0));
    setv(11, 32'h0000B083, 0, 0, 0, 32'd0,
         mk(0,0,0,0,0,0,0,0,0,0,0,0,1));
    setv(12, 32'hFFFFFFFF, 0, 0, 0, 32'd0,
         mk(0,0,0,0,0,0,0,0,0,0,0,0,1));
`ifdef DECODE_RV32M_EN
    setv(13, 32'h022081B3, 3, 1, 2, 32'd0,
         mk(1,0,0,0,0,1,0,0,0,0,0,0,0));
`else
    setv(13, 32'h022081B3, 0, 0, 0, 32'd0,
         mk(0,0,0,0,0,0,0,0,0,0,0,0,1));
`endif
    setv(14, 32'h00500090, 0, 0, 0, 32'd0,
         mk(0,0,0,0,0,0,0,0,0,0,0,0,1));
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_instr = v_ins[i];
      in_pc    = 32'h1000 + 32'(4 * i);
      step();
      if (v_ctl[i][0]) exp_cnt++;
      nchk++;
      if (out_valid !== 1'b1 || out_pc !== 32'h1000 + 32'(4 * i)) begin
        nerr++;
        $display("FAIL dec%0d_valid_pc got %b/%h", i, out_valid, out_pc);
      end
      nchk++;
      if (ctrl !== v_ctl[i]) begin
        nerr++;
        $display("FAIL dec%0d_ctrl got %h want %h", i, ctrl, v_ctl[i]);
      end
      nchk++;
      if (imm !== v_imm[i]) begin
        nerr++;
        $display("FAIL dec%0d_imm got %h want %h", i, imm, v_imm[i]);
      end
      nchk++;
      if ({rd, rs1, rs2} !== {5'(v_rd[i]), 5'(v_rs1[i]), 5'(v_rs2[i])}) begin
        nerr++;
        $display("FAIL dec%0d_regs got %0d %0d %0d want %0d %0d %0d",
                 i, rd, rs1, rs2, v_rd[i], v_rs1[i], v_rs2[i]);
      end
    end
    in_valid = 1'b0;
    step();
    nchk++;
    if (out_valid !== 1'b0 || ctrl !== '0) begin
      nerr++;
      $display("FAIL dec_drain got %b ctrl=%h want 0", out_valid, ctrl);
    end
    nchk++;
    if (illegal_cnt !== 8'(exp_cnt)) begin
      nerr++;
      $display("FAIL dec_cnt got %0d want %0d", illegal_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      in_instr = (32'(n) << 20) | (32'(n) << 7) | 32'h13;
      step();
      nchk++;
      if (rd !== 5'd1 || imm !== 32'd1 || out_valid !== 1'b1) begin
        nerr++;
        $display("FAIL bp_hold%0d got rd=%0d imm=%h want 1", n, rd, imm);
      end
      nchk++;
      if (in_ready !== (n == 1)) begin
        nerr++;
        $display("FAIL bp_ready%0d got %b want %b", n, in_ready, n == 1);
      end
    end
    out_ready = 1'b1;
    for (int n = 2; n <= 3; n++) begin
      step();
      nchk++;
      if (rd !== 5'(n) || imm !== 32'(n) || in_ready !== 1'b1) begin
        nerr++;
        $display("FAIL bp_drain%0d got rd=%0d rdy=%b want %0d 1",
                 n, rd, in_ready, n);
      end
    end
    in_valid = 1'b0;
    step();
    nchk++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL bp_empty got %b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFFFFFFF;
    step(); step();
    exp_cnt += 2;
    nchk++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL fl_full got rdy=%b vld=%b want 0 1", in_ready, out_valid);
    end
    flush = 1'b1;
    step();
    nchk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL fl_empty got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    nchk++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL fl_dropped got %b want 0", out_valid);
    end
    nchk++;
    if (illegal_cnt !== 8'(exp_cnt)) begin
      nerr++;
      $display("FAIL fl_cnt got %0d want %0d", illegal_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00500093;
    step();
    rst_n = 1'b0;
    step();
    nchk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_cnt !== 8'd0) begin
      nerr++;
      $display("FAIL rm_state got vld=%b rdy=%b cnt=%0d want 0 1 0",
               out_valid, in_ready, illegal_cnt);
    end
    nchk++;
    if (rd !== 5'd0 || imm !== 32'd0) begin
      nerr++;
      $display("FAIL rm_fields got rd=%0d imm=%h want 0", rd, imm);
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    nchk++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rm_after got %b want 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'hFFFFFFFF;
    for (int i = 0; i < 257; i++) begin
      step();
      if (i == 253 || i == 254 || i == 256) begin
        nchk++;
        if (illegal_cnt !== ((i == 253) ? 8'd254 : 8'd255)) begin
          nerr++;
          $display("FAIL sat%0d got %0d want %0d", i, illegal_cnt,
                   (i == 253) ? 254 : 255);
        end
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
